rv_thread_sched: RTL and testbench

//  Barrel-style hardware-thread scheduler that feeds the fetch/decode stage.
//  - Each cycle, picks one ready hardware thread round-robin and issues its PC.
//  - Each thread has at most one instruction in flight, so there are no inter-instruction hazards.
//  - Tracks per-thread PC, redirects (pc_load), memory waits and start/stop control.
//  - Drives dec_pipe_rst so the decoder sees a NOP (ADDI x0,x0,0) on empty slots.

---
 rtl/rv_thread_sched.sv | 188 ++++++++++++++++++
 tb/tb_rv_thread_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_thread_sched.sv
// Barrel hardware-thread scheduler: round-robin issue of one ready thread
// per cycle to fetch, with per-thread PC, redirect, memory-wait and stop.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   thr_start/_tid/_pc              start an IDLE thread at a PC
//   thr_stop/_tid                   stop a thread (deferred if busy)
//   issue_ready                     fetch accepts an issue
//   issue_valid/_tid/_pc            combinational grant
//   dec_pipe_rst                    registered bubble flag for decode
//   retire_valid/_tid/_pc_load/
//     _target/_mem_en               instruction completion from execute
//   mem_done_valid/_tid             memory access completion
//   thr_active, thr_waiting         per-thread status
module rv_thread_sched #(
  parameter int NTHREADS = 4,
  parameter int TID_W    = 2,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                thr_start,
  input  logic [TID_W-1:0]    thr_start_tid,
  input  logic [XLEN-1:0]     thr_start_pc,
  input  logic                thr_stop,
  input  logic [TID_W-1:0]    thr_stop_tid,
  input  logic                issue_ready,
  output logic                issue_valid,
  output logic [TID_W-1:0]    issue_tid,
  output logic [XLEN-1:0]     issue_pc,
  output logic                dec_pipe_rst,
  input  logic                retire_valid,
  input  logic [TID_W-1:0]    retire_tid,
  input  logic                retire_pc_load,
  input  logic [XLEN-1:0]     retire_target,
  input  logic                retire_mem_en,
  input  logic                mem_done_valid,
  input  logic [TID_W-1:0]    mem_done_tid,
  output logic [NTHREADS-1:0] thr_active,
  output logic [NTHREADS-1:0] thr_waiting
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2,
    WAITMEM  = 2'd3
  } thr_st_e;

  thr_st_e             st_q [NTHREADS];
  thr_st_e             st_d [NTHREADS];
  logic [XLEN-1:0]     pc_q [NTHREADS];
  logic [XLEN-1:0]     pc_d [NTHREADS];
  logic [NTHREADS-1:0] sp_q;
  logic [NTHREADS-1:0] sp_d;
  logic [TID_W-1:0]    rr_q;
  logic [TID_W-1:0]    rr_d;
  logic                dec_q;

  logic                gnt_vld;
  logic [TID_W-1:0]    gnt_tid;
  logic                fire;

  // Scan from farthest to nearest offset so the
  // nearest READY thread after rr_q wins.
  always_comb begin
    logic [TID_W-1:0] idx;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_tid = '0;
    for (int k = NTHREADS; k >= 1; k--) begin
      idx = rr_q + TID_W'(k);
      if (st_q[idx] == READY) begin
        gnt_vld = 1'b1;
        gnt_tid = idx;
      end
    end
  end

  assign fire = gnt_vld & issue_ready;

  always_comb begin
    logic [TID_W-1:0] tid_i;
    logic             start_i;
    logic             stop_i;
    logic             ret_i;
    logic             done_i;
    logic             fire_i;
    tid_i   = '0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    ret_i   = 1'b0;
    done_i  = 1'b0;
    fire_i  = 1'b0;
    rr_d    = fire ? gnt_tid : rr_q;
    sp_d    = sp_q;
    for (int i = 0; i < NTHREADS; i++) begin
      st_d[i] = st_q[i];
      pc_d[i] = pc_q[i];
      tid_i   = TID_W'(i);
      start_i = thr_start && (thr_start_tid == tid_i);
      stop_i  = thr_stop && (thr_stop_tid == tid_i);
      ret_i   = retire_valid && (retire_tid == tid_i);
      done_i  = mem_done_valid && (mem_done_tid == tid_i);
      fire_i  = fire && (gnt_tid == tid_i);
      unique case (st_q[i])
        IDLE: begin
          if (start_i && !stop_i) begin
            st_d[i] = READY;
            pc_d[i] = thr_start_pc;
          end
        end
        READY: begin
          // A stop racing an issue cannot cancel the
          // fetch, so it becomes a pending stop.
          if (fire_i) begin
            st_d[i] = INFLIGHT;
            sp_d[i] = stop_i;
          end else if (stop_i) begin
            st_d[i] = IDLE;
          end
        end
        INFLIGHT: begin
          if (stop_i) sp_d[i] = 1'b1;
          if (ret_i) begin
            pc_d[i] = retire_pc_load ? retire_target
                                     : pc_q[i] + XLEN'(4);
            if (retire_mem_en) begin
              st_d[i] = WAITMEM;
            end else if (sp_q[i] || stop_i) begin
              st_d[i] = IDLE;
              sp_d[i] = 1'b0;
            end else begin
              st_d[i] = READY;
            end
          end
        end
        WAITMEM: begin
          if (stop_i) sp_d[i] = 1'b1;
          if (done_i) begin
            if (sp_q[i] || stop_i) begin
              st_d[i] = IDLE;
              sp_d[i] = 1'b0;
            end else begin
              st_d[i] = READY;
            end
          end
        end
        default: st_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHREADS; i++) begin
        st_q[i] <= IDLE;
        pc_q[i] <= '0;
      end
      sp_q  <= '0;
      rr_q  <= TID_W'(NTHREADS - 1);
      dec_q <= 1'b1;
    end else begin
      for (int i = 0; i < NTHREADS; i++) begin
        st_q[i] <= st_d[i];
        pc_q[i] <= pc_d[i];
      end
      sp_q  <= sp_d;
      rr_q  <= rr_d;
      dec_q <= ~fire;
    end
  end

  always_comb begin
    thr_active  = '0;
    thr_waiting = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      thr_active[i]  = (st_q[i] != IDLE);
      thr_waiting[i] = (st_q[i] == WAITMEM);
    end
  end

  assign issue_valid  = gnt_vld;
  assign issue_tid    = gnt_tid;
  assign issue_pc     = pc_q[gnt_tid];
  assign dec_pipe_rst = dec_q;

endmodule

// File: tb/tb_rv_thread_sched.sv
// Directed self-checking bench for rv_thread_sched.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_rv_thread_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        thr_start;
  logic [1:0]  thr_start_tid;
  logic [31:0] thr_start_pc;
  logic        thr_stop;
  logic [1:0]  thr_stop_tid;
  logic        issue_ready;
  logic        issue_valid;
  logic [1:0]  issue_tid;
  logic [31:0] issue_pc;
  logic        dec_pipe_rst;
  logic        retire_valid;
  logic [1:0]  retire_tid;
  logic        retire_pc_load;
  logic [31:0] retire_target;
  logic        retire_mem_en;
  logic        mem_done_valid;
  logic [1:0]  mem_done_tid;
  logic [3:0]  thr_active;
  logic [3:0]  thr_waiting;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv_thread_sched #(
    .NTHREADS(4),
    .TID_W(2),
    .XLEN(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .thr_start(thr_start),
    .thr_start_tid(thr_start_tid),
    .thr_start_pc(thr_start_pc),
    .thr_stop(thr_stop),
    .thr_stop_tid(thr_stop_tid),
    .issue_ready(issue_ready),
    .issue_valid(issue_valid),
    .issue_tid(issue_tid),
    .issue_pc(issue_pc),
    .dec_pipe_rst(dec_pipe_rst),
    .retire_valid(retire_valid),
    .retire_tid(retire_tid),
    .retire_pc_load(retire_pc_load),
    .retire_target(retire_target),
    .retire_mem_en(retire_mem_en),
    .mem_done_valid(mem_done_valid),
    .mem_done_tid(mem_done_tid),
    .thr_active(thr_active),
    .thr_waiting(thr_waiting)
  );

  task automatic clr_in();
    thr_start      = 1'b0;
    thr_start_tid  = '0;
    thr_start_pc   = '0;
    thr_stop       = 1'b0;
    thr_stop_tid   = '0;
    issue_ready    = 1'b0;
    retire_valid   = 1'b0;
    retire_tid     = '0;
    retire_pc_load = 1'b0;
    retire_target  = '0;
    retire_mem_en  = 1'b0;
    mem_done_valid = 1'b0;
    mem_done_tid   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({issue_valid, dec_pipe_rst, thr_active, thr_waiting} !== 10'b01_0000_0000) begin
      n_err++;
      $display("FAIL reset_outs got v=%b d=%b a=%b w=%b want v=0 d=1 a=0 w=0",
               issue_valid, dec_pipe_rst, thr_active, thr_waiting);
    end
    #3 rst_n = 1'b1;
    tick();
    issue_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (issue_valid !== 1'b0 || dec_pipe_rst !== 1'b1) begin
        n_err++;
        $display("FAIL idle_cycle%0d got v=%b d=%b want v=0 d=1",
                 c, issue_valid, dec_pipe_rst);
      end
    end
  endtask

  task automatic test_two_threads();
    logic [1:0]  et [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [31:0] ep [4] = '{32'h100, 32'h200, 32'h104, 32'h204};
    do_reset();
    issue_ready   = 1'b1;
    thr_start     = 1'b1;
    thr_start_tid = 2'd0;
    thr_start_pc  = 32'h100;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (issue_valid !== 1'b1 || issue_tid !== et[i] || issue_pc !== ep[i]) begin
        n_err++;
        $display("FAIL two_issue%0d got v=%b tid=%0d pc=%h want v=1 tid=%0d pc=%h",
                 i, issue_valid, issue_tid, issue_pc, et[i], ep[i]);
      end
      thr_start     = (i == 0);
      thr_start_tid = 2'd2;
      thr_start_pc  = 32'h200;
      retire_valid  = (i > 0);
      retire_tid    = (i > 0) ? et[i-1] : 2'd0;
      tick();
      n_chk++;
      if (dec_pipe_rst !== 1'b0) begin
        n_err++;
        $display("FAIL two_dec%0d got %b want 0", i, dec_pipe_rst);
      end
    end
  endtask

  task automatic test_rr_all();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      thr_start     = 1'b1;
      thr_start_tid = 2'(t);
      thr_start_pc  = 32'h1000 * (t + 1);
      tick();
    end
    thr_start = 1'b0;
    n_chk++;
    if (thr_active !== 4'hF || dec_pipe_rst !== 1'b1) begin
      n_err++;
      $display("FAIL rr_ready got a=%b d=%b want a=1111 d=1", thr_active, dec_pipe_rst);
    end
    issue_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (issue_valid !== 1'b1 || issue_tid !== 2'(k % 4)) begin
        n_err++;
        $display("FAIL rr_grant%0d got v=%b tid=%0d want v=1 tid=%0d",
                 k, issue_valid, issue_tid, k % 4);
      end
      if (k < 4) begin
        retire_valid = (k > 0);
        retire_tid   = 2'(k - 1);
        tick();
      end
    end
    issue_ready  = 1'b0;
    retire_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (dec_pipe_rst !== 1'b1 || issue_tid !== 2'd0 ||
          issue_valid !== 1'b1 || thr_active !== 4'hF || issue_pc !== 32'h1004) begin
        n_err++;
        $display("FAIL rr_stall%0d got d=%b tid=%0d v=%b a=%b pc=%h want d=1 tid=0 v=1 a=1111 pc=1004",
                 c, dec_pipe_rst, issue_tid, issue_valid, thr_active, issue_pc);
      end
    end
    issue_ready = 1'b1;
    tick();
    n_chk++;
    if (dec_pipe_rst !== 1'b0 || issue_tid !== 2'd1) begin
      n_err++;
      $display("FAIL rr_resume got d=%b tid=%0d want d=0 tid=1", dec_pipe_rst, issue_tid);
    end
  endtask

  task automatic test_redirect_mem();
    do_reset();
    issue_ready   = 1'b1;
    thr_start     = 1'b1;
    thr_start_tid = 2'd1;
    thr_start_pc  = 32'h80;
    tick();
    thr_start = 1'b0;
    n_chk++;
    if (issue_tid !== 2'd1 || issue_pc !== 32'h80) begin
      n_err++;
      $display("FAIL rd_first got tid=%0d pc=%h want tid=1 pc=80", issue_tid, issue_pc);
    end
    tick();
    n_chk++;
    if (issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_inflight got v=%b want 0", issue_valid);
    end
    retire_valid   = 1'b1;
    retire_tid     = 2'd1;
    retire_pc_load = 1'b1;
    retire_target  = 32'h40;
    tick();
    retire_valid   = 1'b0;
    retire_pc_load = 1'b0;
    n_chk++;
    if (issue_valid !== 1'b1 || issue_tid !== 2'd1 || issue_pc !== 32'h40) begin
      n_err++;
      $display("FAIL rd_target got v=%b tid=%0d pc=%h want v=1 tid=1 pc=40",
               issue_valid, issue_tid, issue_pc);
    end
    tick();
    retire_valid  = 1'b1;
    retire_tid    = 2'd1;
    retire_mem_en = 1'b1;
    tick();
    retire_valid  = 1'b0;
    retire_mem_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if (thr_waiting !== 4'b0010 || issue_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rd_wait%0d got w=%b v=%b want w=0010 v=0", c, thr_waiting, issue_valid);
      end
      tick();
    end
    mem_done_valid = 1'b1;
    mem_done_tid   = 2'd1;
    tick();
    mem_done_valid = 1'b0;
    n_chk++;
    if (thr_waiting !== 4'b0000 || issue_valid !== 1'b1 ||
        issue_tid !== 2'd1 || issue_pc !== 32'h44) begin
      n_err++;
      $display("FAIL rd_memdone got w=%b v=%b tid=%0d pc=%h want w=0000 v=1 tid=1 pc=44",
               thr_waiting, issue_valid, issue_tid, issue_pc);
    end
  endtask

  task automatic test_stop();
    do_reset();
    thr_start     = 1'b1;
    thr_start_tid = 2'd2;
    thr_start_pc  = 32'h500;
    tick();
    thr_start    = 1'b0;
    thr_stop     = 1'b1;
    thr_stop_tid = 2'd2;
    tick();
    thr_stop = 1'b0;
    n_chk++;
    if (thr_active !== 4'b0000 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stop_ready got a=%b v=%b want a=0000 v=0", thr_active, issue_valid);
    end
    issue_ready   = 1'b1;
    thr_start     = 1'b1;
    thr_start_tid = 2'd3;
    thr_start_pc  = 32'h300;
    tick();
    thr_start = 1'b0;
    tick();
    thr_stop     = 1'b1;
    thr_stop_tid = 2'd3;
    tick();
    thr_stop = 1'b0;
    n_chk++;
    if (thr_active !== 4'b1000 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stop_pend got a=%b v=%b want a=1000 v=0", thr_active, issue_valid);
    end
    retire_valid = 1'b1;
    retire_tid   = 2'd3;
    tick();
    retire_valid = 1'b0;
    n_chk++;
    if (thr_active !== 4'b0000 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stop_retire got a=%b v=%b want a=0000 v=0", thr_active, issue_valid);
    end
    retire_valid = 1'b1;
    retire_tid   = 2'd3;
    tick();
    retire_valid = 1'b0;
    n_chk++;
    if (thr_active !== 4'b0000) begin
      n_err++;
      $display("FAIL stop_idle_retire got a=%b want 0000", thr_active);
    end
    thr_start     = 1'b1;
    thr_start_tid = 2'd3;
    thr_start_pc  = 32'h600;
    thr_stop      = 1'b1;
    thr_stop_tid  = 2'd3;
    tick();
    thr_start = 1'b0;
    thr_stop  = 1'b0;
    n_chk++;
    if (thr_active !== 4'b0000 || issue_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stop_start_same got a=%b v=%b want a=0000 v=0", thr_active, issue_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_ready   = 1'b1;
    thr_start     = 1'b1;
    thr_start_tid = 2'd0;
    thr_start_pc  = 32'h700;
    tick();
    thr_start_tid = 2'd1;
    thr_start_pc  = 32'h800;
    tick();
    thr_start     = 1'b0;
    retire_valid  = 1'b1;
    retire_tid    = 2'd0;
    retire_mem_en = 1'b1;
    tick();
    retire_valid  = 1'b0;
    retire_mem_en = 1'b0;
    issue_ready   = 1'b0;
    n_chk++;
    if (thr_active !== 4'b0011 || thr_waiting !== 4'b0001) begin
      n_err++;
      $display("FAIL ar_busy got a=%b w=%b want a=0011 w=0001", thr_active, thr_waiting);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({issue_valid, dec_pipe_rst, thr_active, thr_waiting} !== 10'b01_0000_0000) begin
      n_err++;
      $display("FAIL ar_async got v=%b d=%b a=%b w=%b want v=0 d=1 a=0 w=0",
               issue_valid, dec_pipe_rst, thr_active, thr_waiting);
    end
    #2 rst_n = 1'b1;
    tick();
    issue_ready    = 1'b1;
    retire_valid   = 1'b1;
    retire_tid     = 2'd1;
    mem_done_valid = 1'b1;
    mem_done_tid   = 2'd0;
    tick();
    retire_valid   = 1'b0;
    mem_done_valid = 1'b0;
    n_chk++;
    if (thr_active !== 4'b0000 || thr_waiting !== 4'b0000 ||
        issue_valid !== 1'b0 || dec_pipe_rst !== 1'b1) begin
      n_err++;
      $display("FAIL ar_late got a=%b w=%b v=%b d=%b want a=0000 w=0000 v=0 d=1",
               thr_active, thr_waiting, issue_valid, dec_pipe_rst);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    test_reset();
    test_two_threads();
    test_rr_all();
    test_redirect_mem();
    test_stop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
